// File: rtl/apb_cmd_master.sv
// apb_cmd_master
// Purpose: upstream APB requester. Commands arrive on a ready/valid port, are
//   buffered in a small FIFO and issued one at a time as APB SETUP/ACCESS
//   transfers. Every transfer that completes produces exactly one response
//   pulse carrying read data, a slave error flag or a timeout flag.
// Ports:
//   clk_i, rst_i (async, active high)
//   cmd_valid_i/cmd_ready_o, cmd_write_i, cmd_addr_i, cmd_wdata_i, cmd_strb_i
//   hold_i         : accelerator start bit, blocks launching new transfers
//   psel_o, penable_o, pwrite_o, paddr_o, pwdata_o, pstrb_o : APB request
//   pready_i, pslverr_i, prdata_i                          : APB completion
//   rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o     : response pulse
//   idle_o         : FIFO empty and no transfer in flight
// Option: define APB_MASTER_TIMEOUT_EN to bound the ACCESS phase to
//   TIMEOUT_CYCLES cycles; otherwise ACCESS waits for the slave indefinitely
//   and rsp_timeout_o is tied low.
module apb_cmd_master #(
  parameter int DATA_WIDTH     = 32,
  parameter int BUS_WIDTH      = 64,
  parameter int ADDR_WIDTH     = 32,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            cmd_valid_i,
  output logic                            cmd_ready_o,
  input  logic                            cmd_write_i,
  input  logic [ADDR_WIDTH-1:0]           cmd_addr_i,
  input  logic [BUS_WIDTH-1:0]            cmd_wdata_i,
  input  logic [BUS_WIDTH/DATA_WIDTH-1:0] cmd_strb_i,
  input  logic                            hold_i,
  output logic                            psel_o,
  output logic                            penable_o,
  output logic                            pwrite_o,
  output logic [ADDR_WIDTH-1:0]           paddr_o,
  output logic [BUS_WIDTH-1:0]            pwdata_o,
  output logic [BUS_WIDTH/DATA_WIDTH-1:0] pstrb_o,
  input  logic                            pready_i,
  input  logic                            pslverr_i,
  input  logic [BUS_WIDTH-1:0]            prdata_i,
  output logic                            rsp_valid_o,
  output logic [BUS_WIDTH-1:0]            rsp_rdata_o,
  output logic                            rsp_err_o,
  output logic                            rsp_timeout_o,
  output logic                            idle_o
);

  localparam int              STRB_W   = BUS_WIDTH / DATA_WIDTH;
  localparam int              PTR_W    = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0]  FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("apb_cmd_master: FIFO_DEPTH must be a power of two >= 2");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("apb_cmd_master: TIMEOUT_CYCLES must be >= 2");
  end

  typedef struct packed {
    logic                  write;
    logic [ADDR_WIDTH-1:0] addr;
    logic [BUS_WIDTH-1:0]  wdata;
    logic [STRB_W-1:0]     strb;
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  // ---------------------------------------------------------------------
  // Command FIFO. Ready comes only from the registered count, so a pop in
  // the same cycle never opens a slot for a push at full. The head is only
  // consumed by the FSM one cycle after it was written (no bypass).
  // ---------------------------------------------------------------------
  cmd_t             mem [FIFO_DEPTH];
  cmd_t             head;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             push;
  logic             pop;
  logic             fifo_empty;

  assign cmd_ready_o = (count != FULL_CNT);
  assign fifo_empty  = (count == '0);
  assign push        = cmd_valid_i & cmd_ready_o;
  assign head        = mem[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr] <= cmd_t'{cmd_write_i, cmd_addr_i, cmd_wdata_i, cmd_strb_i};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + (PTR_W + 1)'(push) - (PTR_W + 1)'(pop);
    end
  end

  // ---------------------------------------------------------------------
  // Transfer FSM
  // ---------------------------------------------------------------------
  state_t               state_q;
  state_t               state_d;
  logic                 done;
  logic                 done_err;
  logic [BUS_WIDTH-1:0] done_rdata;
  logic                 expire;

  always_comb begin
    state_d    = state_q;
    pop        = 1'b0;
    done       = 1'b0;
    done_err   = 1'b0;
    done_rdata = '0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty && !hold_i) begin
          pop     = 1'b1;
          state_d = SETUP;
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        // pready has priority over both abort and timeout expiry.
        if (pready_i) begin
          done     = 1'b1;
          done_err = pslverr_i;
          if (!pwrite_o && !pslverr_i) done_rdata = prdata_i;
        end else if (pslverr_i || expire) begin
          done     = 1'b1;
          done_err = 1'b1;
        end
        if (done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      psel_o      <= 1'b0;
      penable_o   <= 1'b0;
      pwrite_o    <= 1'b0;
      paddr_o     <= '0;
      pwdata_o    <= '0;
      pstrb_o     <= '0;
      rsp_valid_o <= 1'b0;
      rsp_err_o   <= 1'b0;
      rsp_rdata_o <= '0;
    end else begin
      state_q     <= state_d;
      rsp_valid_o <= done;
      rsp_err_o   <= done_err;
      rsp_rdata_o <= done_rdata;
      if (pop) begin
        psel_o    <= 1'b1;
        penable_o <= 1'b0;
        pwrite_o  <= head.write;
        paddr_o   <= head.addr;
        // Reads never drive write data or strobes onto the bus.
        pwdata_o  <= head.write ? head.wdata : '0;
        pstrb_o   <= head.write ? head.strb  : '0;
      end else if (state_q == SETUP) begin
        penable_o <= 1'b1;
      end else if (done) begin
        psel_o    <= 1'b0;
        penable_o <= 1'b0;
        pwrite_o  <= 1'b0;
        paddr_o   <= '0;
        pwdata_o  <= '0;
        pstrb_o   <= '0;
      end
    end
  end

  assign idle_o = fifo_empty && (state_q == IDLE);

`ifdef APB_MASTER_TIMEOUT_EN
  // Counts ACCESS cycles without pready; expiry is seen in the cycle where
  // the count has reached TIMEOUT_CYCLES-1, giving exactly TIMEOUT_CYCLES
  // ACCESS cycles before the bus is released.
  localparam int TO_W = $clog2(TIMEOUT_CYCLES);
  logic [TO_W-1:0] to_cnt;

  assign expire = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      to_cnt        <= '0;
      rsp_timeout_o <= 1'b0;
    end else begin
      if (state_q == SETUP) begin
        to_cnt <= '0;
      end else if (state_q == ACCESS && !pready_i) begin
        to_cnt <= to_cnt + TO_W'(1);
      end
      rsp_timeout_o <= (state_q == ACCESS) && !pready_i && !pslverr_i && expire;
    end
  end
`else
  assign expire        = 1'b0;
  assign rsp_timeout_o = 1'b0;
`endif

endmodule
